mcu_cmd_seq: RTL and testbench

//  Command sequencer feeding the memory control unit's phase and block-change inputs.
//  - Accepts opcodes from the host GPIO path over a valid/ready handshake.
//  - Drives the 2-bit phase code {o_eop,o_sop}: LOAD=00, PROC=01, OUT=10; 11 is never driven.
//  - Generates the edge-detected block-change strobe o_chblk and counts blocks per phase.

---
 rtl/mcu_cmd_seq_if.sv | 10 +
 rtl/mcu_cmd_seq.sv | 170 +++++++++++++++++
 tb/tb_mcu_cmd_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_cmd_seq_if.sv
// Host-to-sequencer command handshake: opcode with valid/ready flow control.
// The host (master) holds i_cmd stable while o_cmd_ready is low.
interface mcu_cmd_seq_if;
  logic       i_cmd_valid;
  logic [2:0] i_cmd;
  logic       o_cmd_ready;

  modport master (output i_cmd_valid, output i_cmd, input o_cmd_ready);
  modport slave  (input i_cmd_valid, input i_cmd, output o_cmd_ready);
endinterface

// File: rtl/mcu_cmd_seq.sv
// Command sequencer driving the MCU phase code {o_eop,o_sop}, block-change strobe and block count.
// Optional sticky illegal-command flag enabled by defining MCU_CMD_SEQ_ERR_EN.
module mcu_cmd_seq #(
  parameter int N_BLOCKS   = 16,
  parameter int CHBLK_W    = 2,
  parameter int SETTLE_CYC = 1,
  localparam int BW        = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  mcu_cmd_seq_if.slave  cmd,
  output logic          o_sop,
  output logic          o_eop,
  output logic          o_chblk,
  output logic [BW-1:0] o_blk_cnt,
  output logic          o_last_blk,
  output logic          o_err
);

  localparam int CMAX = (CHBLK_W > SETTLE_CYC) ? CHBLK_W : SETTLE_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(N_BLOCKS - 1);

  localparam logic [2:0] OP_GO_LOAD  = 3'd1;
  localparam logic [2:0] OP_GO_PROC  = 3'd2;
  localparam logic [2:0] OP_GO_OUT   = 3'd3;
  localparam logic [2:0] OP_NEXT_BLK = 3'd4;

  typedef enum logic [1:0] {
    ST_READY, ST_SETTLE, ST_PULSE_HI, ST_PULSE_LO
  } state_t;

  // Encoding is the phase code itself: {o_eop,o_sop}.
  typedef enum logic [1:0] {
    PH_LOAD = 2'b00, PH_PROC = 2'b01, PH_OUT = 2'b10
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_LOAD: return PH_PROC;
      PH_PROC: return PH_OUT;
      default: return PH_LOAD;
    endcase
  endfunction

  state_t        state_q;
  phase_t        phase_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          chblk_q;
  logic [BW-1:0] blk_q;
  logic          last_q;

  logic          accept;
  logic          is_go;
  logic          go_legal;
  phase_t        go_tgt;
  logic [BW-1:0] blk_next;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_go  = 1'b0;
    go_tgt = PH_LOAD;
    case (cmd.i_cmd)
      OP_GO_LOAD: begin is_go = 1'b1; go_tgt = PH_LOAD; end
      OP_GO_PROC: begin is_go = 1'b1; go_tgt = PH_PROC; end
      OP_GO_OUT:  begin is_go = 1'b1; go_tgt = PH_OUT;  end
      default:    ;
    endcase
    accept   = cmd.i_cmd_valid & ready_q;
    go_legal = is_go && (go_tgt == next_phase(phase_q));
    blk_next = (blk_q == LAST_BLK) ? '0 : blk_q + BW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_READY;
      phase_q <= PH_LOAD;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      chblk_q <= 1'b0;
      blk_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_READY: begin
          if (accept) begin
            if (go_legal) begin
              phase_q <= go_tgt;
              blk_q   <= '0;
              last_q  <= (N_BLOCKS == 1);
              state_q <= ST_SETTLE;
              ready_q <= 1'b0;
              cnt_q   <= CW'(SETTLE_CYC - 1);
            end else if (cmd.i_cmd == OP_NEXT_BLK) begin
              chblk_q <= 1'b1;
              blk_q   <= blk_next;
              last_q  <= (blk_next == LAST_BLK);
              state_q <= ST_PULSE_HI;
              ready_q <= 1'b0;
              cnt_q   <= CW'(CHBLK_W - 1);
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_PULSE_HI: begin
          if (cnt_q == '0) begin
            state_q <= ST_PULSE_LO;
            chblk_q <= 1'b0;
            cnt_q   <= CW'(CHBLK_W - 1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_PULSE_LO: begin
          // The low gap guarantees a clean edge before any following strobe or phase change.
          if (cnt_q == '0) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
          chblk_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MCU_CMD_SEQ_ERR_EN
  localparam logic [2:0] OP_CLR_ERR = 3'd5;

  logic illegal;
  logic err_q;

  assign illegal = (is_go && !go_legal) || (cmd.i_cmd[2:1] == 2'b11);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      if (illegal)                       err_q <= 1'b1;
      else if (cmd.i_cmd == OP_CLR_ERR)  err_q <= 1'b0;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign cmd.o_cmd_ready = ready_q;
  assign o_sop           = phase_q[0];
  assign o_eop           = phase_q[1];
  assign o_chblk         = chblk_q;
  assign o_blk_cnt       = blk_q;
  assign o_last_blk      = last_q;

endmodule

// File: tb/tb_mcu_cmd_seq.sv
// Scoreboard bench for mcu_cmd_seq: driver updates a phase/count model and queues expectations,
// an independent monitor compares each accepted command's effect, ready-low time and strobe shape.
module tb_mcu_cmd_seq;

  localparam int N  = 16;
  localparam int W  = 2;
  localparam int S  = 1;
  localparam int BW = $clog2(N);
`ifdef MCU_CMD_SEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          sop, eop, chblk, last_blk, err;
  logic [BW-1:0] blk_cnt;

  mcu_cmd_seq_if cmd_if ();

  mcu_cmd_seq #(.N_BLOCKS(N), .CHBLK_W(W), .SETTLE_CYC(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .o_sop      (sop),
    .o_eop      (eop),
    .o_chblk    (chblk),
    .o_blk_cnt  (blk_cnt),
    .o_last_blk (last_blk),
    .o_err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] phase;
    int         blk;
    bit         last;
    bit         err;
    int         busy;
    int         hi;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase index 0/1/2 = LOAD/PROC/OUT, plain modular arithmetic.
  int m_ph  = 0;
  int m_blk = 0;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ph_code(input int p);
    case (p)
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic void model_reset();
    m_ph  = 0;
    m_blk = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_apply(input int op);
    exp_t e;
    e.busy = 0;
    e.hi   = 0;
    case (op)
      1, 2, 3: begin
        if (op - 1 == (m_ph + 1) % 3) begin
          m_ph   = op - 1;
          m_blk  = 0;
          e.busy = S;
        end else if (ERR_EN) begin
          m_err = 1'b1;
        end
      end
      4: begin
        m_blk  = (m_blk + 1) % N;
        e.busy = 2 * W;
        e.hi   = W;
      end
      5: if (ERR_EN) m_err = 1'b0;
      6, 7: if (ERR_EN) m_err = 1'b1;
      default: ;
    endcase
    e.phase = ph_code(m_ph);
    e.blk   = m_blk;
    e.last  = (m_blk == N - 1);
    e.err   = m_err;
    sb.push_back(e);
  endfunction

  // Present one command and hold it until the sequencer takes it.
  task automatic send(input logic [2:0] op);
    int n;
    @(posedge clk);
    #1;
    cmd_if.i_cmd_valid = 1'b1;
    cmd_if.i_cmd       = op;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_if.o_cmd_ready && n < 100);
    if (!cmd_if.o_cmd_ready) begin
      check("ready_timeout", cmd_if.o_cmd_ready, 1);
    end else begin
      model_apply(op);
    end
    @(posedge clk);
    #1;
    cmd_if.i_cmd_valid = 1'b0;
    cmd_if.i_cmd       = 3'($urandom);
  endtask

  // Monitor: an accept is seen at the negedge before the edge that takes it.
  initial begin
    exp_t e;
    int   busy, hi, rises, moved;
    bit   prev;
    forever begin
      @(negedge clk);
      while (rst && cmd_if.i_cmd_valid && cmd_if.o_cmd_ready) begin
        @(negedge clk);
        if (!rst) break;
        check("sb_depth", sb.size(), 1);
        if (sb.size() == 0) break;
        e = sb.pop_front();
        check("phase", {eop, sop}, e.phase);
        check("blk_cnt", blk_cnt, e.blk);
        check("last_blk", last_blk, e.last);
        check("err", err, e.err);
        busy = 0; hi = 0; rises = 0; moved = 0; prev = 1'b0;
        while (rst && !cmd_if.o_cmd_ready && busy < 200) begin
          if (chblk) hi++;
          if (chblk && !prev) rises++;
          if ({eop, sop} !== e.phase) moved++;
          prev = chblk;
          busy++;
          @(negedge clk);
        end
        if (rst) begin
          check("ready_low_cycles", busy, e.busy);
          check("chblk_high_cycles", hi, e.hi);
          check("chblk_rises", rises, (e.hi > 0) ? 1 : 0);
          check("phase_moved_while_busy", moved, 0);
          check("chblk_idle", chblk, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r;
    logic [2:0] op;
    rst = 1'b0;
    cmd_if.i_cmd_valid = 1'b0;
    cmd_if.i_cmd       = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_sop", sop, 0);
    check("rst_eop", eop, 0);
    check("rst_chblk", chblk, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_last_blk", last_blk, 0);
    check("rst_ready", cmd_if.o_cmd_ready, 1);
    check("rst_err", err, 0);

    // Legal phase cycle, then a full block wrap in LOAD.
    send(3'd2); send(3'd3); send(3'd1);
    repeat (N + 1) send(3'd4);
    // Illegal GOs and opcodes, error clear.
    send(3'd3); send(3'd5);
    send(3'd1); send(3'd6); send(3'd0); send(3'd5); send(3'd7); send(3'd5);
    // GO held while a strobe is in flight.
    send(3'd4); send(3'd2);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = 3'd4;
      else if (r < 60) op = 3'((m_ph + 1) % 3 + 1);
      else             op = 3'($urandom_range(0, 7));
      send(op);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a strobe, PROC phase, count 5.
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    sb.delete();
    send(3'd2);
    repeat (5) send(3'd4);
    @(negedge clk);
    #1;
    check("pre_rst_chblk", chblk, 1);
    check("pre_rst_blk_cnt", blk_cnt, 5);
    rst = 1'b0;
    #1;
    check("async_rst_chblk", chblk, 0);
    check("async_rst_phase", {eop, sop}, 2'b00);
    check("async_rst_blk_cnt", blk_cnt, 0);
    check("async_rst_ready", cmd_if.o_cmd_ready, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    sb.delete();
    send(3'd2);
    send(3'd4);
    repeat (10) @(negedge clk);
    check("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
